// File: rtl/alu_issue_scoreboard_if.sv
// Issue-side handshake bundle between the decoder and the arithmetic-unit scoreboard.
// The decoder drives the instruction fields; the scoreboard answers with in_ready.
interface alu_issue_scoreboard_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_opcode;
  logic [4:0]  in_dst;
  logic [4:0]  in_src1;
  logic [4:0]  in_src2;
  logic [31:0] in_a;
  logic [31:0] in_b;

  modport master (
    output in_valid, in_opcode, in_dst, in_src1, in_src2, in_a, in_b,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_opcode, in_dst, in_src1, in_src2, in_a, in_b,
    output in_ready
  );
endinterface

// File: rtl/alu_issue_scoreboard.sv
// Issue front end for the pipelined arithmetic unit: hazard/slot checks, operand launch,
// and a latency-indexed reservation shift register that produces one writeback per cycle.
module alu_issue_scoreboard #(
  parameter int LAT_ADD  = 27,
  parameter int LAT_MUL  = 13,
  parameter int LAT_FADD = 2,
  parameter int LAT_FMUL = 6,
  parameter int MAXLAT   = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  alu_issue_scoreboard_if.slave       in_if,
  output logic [31:0]                 alu_a,
  output logic [31:0]                 alu_b,
  output logic [2:0]                  alu_opcode,
  output logic                        alu_issue,
  output logic                        wb_valid,
  output logic [4:0]                  wb_dst,
  output logic [2:0]                  wb_opcode,
  output logic                        illegal,
  output logic [5:0]                  pending_count
);

  localparam int         LW         = $clog2(MAXLAT);
  localparam logic [2:0] OP_ILLEGAL = 3'b110;

  function automatic logic [LW-1:0] lat_of(input logic [2:0] op);
    logic [LW-1:0] lat;
    case (op)
      3'b000, 3'b001, 3'b010, 3'b011: lat = LW'(LAT_ADD);
      3'b100:                         lat = LW'(LAT_MUL);
      3'b101:                         lat = LW'(LAT_FADD);
      3'b111:                         lat = LW'(LAT_FMUL);
      default:                        lat = LW'(1);
    endcase
    return lat;
  endfunction

  // res_v_r[i] set means some operation retires i+1 edges from now
  logic [MAXLAT-1:0] res_v_r;
  logic [4:0]        res_dst_r [MAXLAT];
  logic [2:0]        res_op_r  [MAXLAT];
  logic [31:0]       busy_r;

  logic [31:0]       alu_a_r;
  logic [31:0]       alu_b_r;
  logic [2:0]        alu_opcode_r;
  logic              alu_issue_r;
  logic              wb_valid_r;
  logic [4:0]        wb_dst_r;
  logic [2:0]        wb_opcode_r;
  logic              illegal_r;
  logic [5:0]        pending_r;

  logic [LW-1:0]     lat_s;
  logic [LW-1:0]     slot_s;
  logic              reg_hazard_s;
  logic              wb_hit_s;
  logic              ready_s;
  logic              accept_s;
  logic              issue_s;
  logic              illegal_s;
  logic [5:0]        pending_next_s;

  // Issue decision: register hazards, no-bypass on the retiring tag, and retirement-slot collision
  always_comb begin
    lat_s        = lat_of(in_if.in_opcode);
    slot_s       = lat_s - LW'(1);
    reg_hazard_s = busy_r[in_if.in_dst] | busy_r[in_if.in_src1] | busy_r[in_if.in_src2];
    wb_hit_s     = wb_valid_r && ((wb_dst_r == in_if.in_dst) ||
                                  (wb_dst_r == in_if.in_src1) ||
                                  (wb_dst_r == in_if.in_src2));
    if (in_if.in_opcode == OP_ILLEGAL) begin
      ready_s = 1'b1;
    end else begin
      ready_s = !reg_hazard_s && !wb_hit_s && !res_v_r[lat_s];
    end
    accept_s  = in_if.in_valid && ready_s;
    issue_s   = accept_s && (in_if.in_opcode != OP_ILLEGAL);
    illegal_s = accept_s && (in_if.in_opcode == OP_ILLEGAL);
  end

  assign in_if.in_ready = ready_s;

  // In-flight count: the retirement edge is the one where res[0] moves into writeback
  always_comb begin
    case ({issue_s, res_v_r[0]})
      2'b10:   pending_next_s = pending_r + 6'd1;
      2'b01:   pending_next_s = pending_r - 6'd1;
      default: pending_next_s = pending_r;
    endcase
  end

  // Reservation shift register; a new issue lands in the slot its latency selects
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_v_r <= '0;
      for (int i = 0; i < MAXLAT; i++) begin
        res_dst_r[i] <= 5'd0;
        res_op_r[i]  <= 3'd0;
      end
    end else begin
      res_v_r <= {1'b0, res_v_r[MAXLAT-1:1]};
      for (int i = 0; i < MAXLAT - 1; i++) begin
        res_dst_r[i] <= res_dst_r[i+1];
        res_op_r[i]  <= res_op_r[i+1];
      end
      res_dst_r[MAXLAT-1] <= 5'd0;
      res_op_r[MAXLAT-1]  <= 3'd0;
      if (issue_s) begin
        res_v_r[slot_s]   <= 1'b1;
        res_dst_r[slot_s] <= in_if.in_dst;
        res_op_r[slot_s]  <= in_if.in_opcode;
      end
    end
  end

  // Busy bits: the retiring tag can never equal a newly issued dst, so set/clear never collide
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 32'd0;
    end else begin
      if (res_v_r[0]) begin
        busy_r[res_dst_r[0]] <= 1'b0;
      end
      if (issue_s) begin
        busy_r[in_if.in_dst] <= 1'b1;
      end
    end
  end

  // Operand launch to the arithmetic unit; operands hold when nothing issues
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a_r      <= 32'd0;
      alu_b_r      <= 32'd0;
      alu_opcode_r <= 3'd0;
      alu_issue_r  <= 1'b0;
      illegal_r    <= 1'b0;
    end else begin
      alu_issue_r <= issue_s;
      illegal_r   <= illegal_s;
      if (issue_s) begin
        alu_a_r      <= in_if.in_a;
        alu_b_r      <= in_if.in_b;
        alu_opcode_r <= in_if.in_opcode;
      end
    end
  end

  // Writeback strobe and in-flight counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_r  <= 1'b0;
      wb_dst_r    <= 5'd0;
      wb_opcode_r <= 3'd0;
      pending_r   <= 6'd0;
    end else begin
      wb_valid_r  <= res_v_r[0];
      wb_dst_r    <= res_dst_r[0];
      wb_opcode_r <= res_op_r[0];
      pending_r   <= pending_next_s;
    end
  end

  assign alu_a         = alu_a_r;
  assign alu_b         = alu_b_r;
  assign alu_opcode    = alu_opcode_r;
  assign alu_issue     = alu_issue_r;
  assign wb_valid      = wb_valid_r;
  assign wb_dst        = wb_dst_r;
  assign wb_opcode     = wb_opcode_r;
  assign illegal       = illegal_r;
  assign pending_count = pending_r;

endmodule

// File: doc/alu_issue_scoreboard.md
Name: alu_issue_scoreboard

Overview:
- Front end for the pipelined arithmetic unit.
- Accepts decoded instructions over a valid/ready handshake and drives the arithmetic unit's operand and opcode inputs.
- Tracks every in-flight operation by its fixed per-class latency and produces the writeback strobe and destination tag when the result emerges.
- Stalls on register hazards and on writeback-slot collisions, so no two results ever retire in the same cycle.

Parameters:
- LAT_ADD, 27, latency in cycles for opcodes 000/001/010/011.
- LAT_MUL, 13, latency in cycles for opcode 100.
- LAT_FADD, 2, latency in cycles for opcode 101.
- LAT_FMUL, 6, latency in cycles for opcode 111.
- MAXLAT, 32, depth of the reservation shift register. Every LAT_* must be in the range 1..MAXLAT-1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  instruction offered.
- in_ready  out  1  combinational; instruction accepted when in_valid and in_ready are both high.
- in_opcode  in  3  ADD 000, SUB 001, ADDWC 010, SUBWB 011, MUL 100, FADD 101, FMUL 111; 110 is illegal.
- in_dst  in  5  destination register tag.
- in_src1, in_src2  in  5 each  source register tags.
- in_a, in_b  in  32 each  operand values.
- alu_a, alu_b  out  32 each  registered operands to the arithmetic unit.
- alu_opcode  out  3  registered opcode to the arithmetic unit.
- alu_issue  out  1  one-cycle pulse marking a new issue.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_dst  out  5  destination tag of the retiring operation.
- wb_opcode  out  3  opcode of the retiring operation.
- illegal  out  1  one-cycle pulse on acceptance of opcode 110.
- pending_count  out  6  number of operations in flight.

Behaviour:
- Reset: asynchronous. All outputs, reservation slots and busy bits go to 0 immediately. Operations in flight at reset are discarded and never produce wb_valid.
- State:
  - Reservation shift register res[0..MAXLAT-1], each entry {valid, dst[4:0], opcode[2:0]}. Every cycle res[i] <= res[i+1], and res[MAXLAT-1] <= 0.
  - 32-bit busy vector, one bit per register tag.
- Issue condition: in_ready = !busy[in_dst] && !busy[in_src1] && !busy[in_src2] && !res[L].valid, where L is the latency of in_opcode.
  - res[L] is the entry that would shift into res[L-1] on the same edge. This check guarantees the retirement cycle is unclaimed.
  - For opcode 110, in_ready is 1 unconditionally.
- On acceptance of a legal opcode at edge E0:
  - res[L-1] <= {1, in_dst, in_opcode}.
  - busy[in_dst] <= 1.
  - alu_a, alu_b and alu_opcode are loaded.
  - alu_issue = 1 for the cycle after E0.
- Writeback: wb_valid, wb_dst and wb_opcode are registered from res[0].
  - An operation issued at edge E0 shows wb_valid = 1 in the cycle after edge E0+L, for exactly one cycle.
  - busy[wb tag] clears on that same edge.
  - There is no bypass: an instruction that depends on the retiring tag is still stalled in that cycle and may issue on the next cycle.
- Illegal opcode: accepted without stalling. No reservation, no busy update, no ALU update. illegal = 1 for one cycle.
- When no issue occurs, alu_a, alu_b and alu_opcode hold their last issued values.
- pending_count: +1 on legal issue, -1 on wb_valid. Both in the same cycle leaves the count unchanged.
- Back-to-back issue: allowed every cycle provided there are no hazards and no slot collision.
- Mixed latencies: later-issued, shorter operations may retire before earlier ones; retirement order follows the slot map, not issue order.

Test Plan:
- Reset, then ADD dst=3 with a=5, b=7 at E0 -> alu_issue in the cycle after E0; wb_valid with wb_dst=3 and wb_opcode=000 in the cycle after E0+27; pending_count goes 1 then back to 0.
- MUL dst=4 at E0, then FADD dst=5 at E0+11 -> FADD's L=2 places it in the same retirement slot as MUL (E0+13), so in_ready=0 for the FADD. FADD issues at E0+12 and retires after E0+14; MUL retires after E0+13.
- FMUL dst=6, then ADD src1=6 on the next cycle -> in_ready stays 0 until the FMUL's wb_valid cycle has passed; the ADD issues one cycle after wb_dst=6.
- Opcode 110 with dst=9 -> accepted immediately, illegal pulses for one cycle, busy[9] stays 0, no wb_valid ever occurs.
- Four independent FADDs on dst=1,2,3,4 in consecutive cycles -> four consecutive wb_valid cycles, tags 1,2,3,4; pending_count peaks at 2.
- Issue MUL dst=8, assert reset 5 cycles later -> all outputs 0 immediately; no wb_valid afterwards; an instruction reading register 8 is accepted right after reset deasserts.
